// File: rtl/ps2_dual_keymap.sv
// PS/2 keyboard front end: synchronise and filter the PS/2 lines, deframe 11-bit frames,
// decode make/break/extended prefixes and hold a pressed/released level per mapped key.
module ps2_dual_keymap #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [6:0] p1_inputs,
    output logic [6:0] p2_inputs,
    output logic       scan_valid,
    output logic [7:0] scan_code,
    output logic       frame_error
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {DEC_NORM, DEC_BRK, DEC_EXT, DEC_EXTBRK} dec_state_t;

    typedef struct packed {
        logic       hit;
        logic       p2;
        logic [2:0] idx;
    } key_map_t;

    logic [1:0]    clk_sync, data_sync;
    logic          clk_filt;
    logic [FW-1:0] filt_cnt;
    logic          filt_accept, fall_edge, data_bit;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_filt  <= 1'b1;
            filt_cnt  <= '0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            if (clk_sync[1] == clk_filt)
                filt_cnt <= '0;
            else if (filt_accept) begin
                clk_filt <= clk_sync[1];
                filt_cnt <= '0;
            end else
                filt_cnt <= filt_cnt + FW'(1);
        end
    end

    // The FILTER_LEN-th consecutive differing sample is the one that flips the filtered clock.
    assign filt_accept = (clk_sync[1] != clk_filt) && (filt_cnt == FW'(FILTER_LEN - 1));
    assign fall_edge   = filt_accept && clk_filt;
    assign data_bit    = data_sync[1];

    rx_state_t     rx_state, rx_next;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shift, shift_n;
    logic          parity_bit, parity_n;
    logic [TW-1:0] to_cnt;
    logic          good_byte, bad_frame;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        rx_next   = rx_state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        parity_n  = parity_bit;
        good_byte = 1'b0;
        bad_frame = 1'b0;
        if (rx_state != RX_IDLE && !fall_edge && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            rx_next   = RX_IDLE;
            bad_frame = 1'b1;
        end else if (fall_edge) begin
            case (rx_state)
                RX_IDLE: if (!data_bit) begin
                    rx_next   = RX_DATA;
                    bit_cnt_n = 3'd0;
                end
                RX_DATA: begin
                    shift_n   = {data_bit, shift[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) rx_next = RX_PARITY;
                end
                RX_PARITY: begin
                    parity_n = data_bit;
                    rx_next  = RX_STOP;
                end
                RX_STOP: begin
                    if (data_bit && (^{shift, parity_bit})) good_byte = 1'b1;
                    else                                    bad_frame = 1'b1;
                    rx_next = RX_IDLE;
                end
                default: rx_next = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state    <= RX_IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            parity_bit  <= 1'b0;
            to_cnt      <= '0;
            scan_valid  <= 1'b0;
            scan_code   <= '0;
            frame_error <= 1'b0;
        end else begin
            rx_state    <= rx_next;
            bit_cnt     <= bit_cnt_n;
            shift       <= shift_n;
            parity_bit  <= parity_n;
            to_cnt      <= (rx_state == RX_IDLE || fall_edge) ? '0 : to_cnt + TW'(1);
            scan_valid  <= good_byte;
            frame_error <= bad_frame;
            if (good_byte) scan_code <= shift;
        end
    end

    function automatic key_map_t lookup(input logic ext, input logic [7:0] code);
        key_map_t m;
        m = '0;
        case ({ext, code})
            9'h015: m = '{1'b1, 1'b0, 3'd0};
            9'h01C: m = '{1'b1, 1'b0, 3'd1};
            9'h023: m = '{1'b1, 1'b0, 3'd2};
            9'h01D: m = '{1'b1, 1'b0, 3'd3};
            9'h01B: m = '{1'b1, 1'b0, 3'd4};
            9'h02B: m = '{1'b1, 1'b0, 3'd5};
            9'h034: m = '{1'b1, 1'b0, 3'd6};
            9'h03B: m = '{1'b1, 1'b1, 3'd0};
            9'h042: m = '{1'b1, 1'b1, 3'd5};
            9'h04B: m = '{1'b1, 1'b1, 3'd6};
            9'h16B: m = '{1'b1, 1'b1, 3'd1};
            9'h174: m = '{1'b1, 1'b1, 3'd2};
            9'h175: m = '{1'b1, 1'b1, 3'd3};
            9'h172: m = '{1'b1, 1'b1, 3'd4};
            default: m = '0;
        endcase
        return m;
    endfunction

    dec_state_t dec_state, dec_next;
    logic       key_evt, key_make, key_ext;
    key_map_t   key;

    always_comb begin
        dec_next = dec_state;
        key_evt  = 1'b0;
        key_make = 1'b0;
        key_ext  = 1'b0;
        if (frame_error)
            dec_next = DEC_NORM;
        else if (scan_valid) begin
            case (dec_state)
                DEC_NORM:
                    if (scan_code == 8'hE0)      dec_next = DEC_EXT;
                    else if (scan_code == 8'hF0) dec_next = DEC_BRK;
                    else begin
                        key_evt  = 1'b1;
                        key_make = 1'b1;
                    end
                DEC_BRK: begin
                    key_evt  = 1'b1;
                    dec_next = DEC_NORM;
                end
                DEC_EXT:
                    if (scan_code == 8'hF0) dec_next = DEC_EXTBRK;
                    else begin
                        key_evt  = 1'b1;
                        key_make = 1'b1;
                        key_ext  = 1'b1;
                        dec_next = DEC_NORM;
                    end
                DEC_EXTBRK: begin
                    key_evt  = 1'b1;
                    key_ext  = 1'b1;
                    dec_next = DEC_NORM;
                end
                default: dec_next = DEC_NORM;
            endcase
        end
    end

    assign key = lookup(key_ext, scan_code);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dec_state <= DEC_NORM;
            p1_inputs <= '0;
            p2_inputs <= '0;
        end else begin
            dec_state <= dec_next;
            if (key_evt && key.hit) begin
                if (key.p2) p2_inputs[key.idx] <= key_make;
                else        p1_inputs[key.idx] <= key_make;
            end
        end
    end
endmodule
